data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable 32-bit data memory controller with a zeroing sweep after reset.
// Optional DM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [2:0]  funct3,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misalign_err
);

  typedef enum logic {StClear, StRun} state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_clr_idx;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic [1:0]       w_eff_off;
  logic             w_accept;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_err;
  logic             w_we;
  logic [3:0]       w_be;
  logic [31:0]      w_lane;
  logic [31:0]      w_word;
  logic [31:0]      w_shift;
  logic [31:0]      w_load;
  logic             w_unused_addr;

  assign w_idx         = addr[IDX_W+1:2];
  assign w_off         = addr[1:0];
  assign w_unused_addr = ^addr[31:IDX_W+2];
  assign w_accept      = req_valid & r_ready;

  // Reserved encodings, plus unsigned sizes which have no store form.
  assign w_illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (we & funct3[2]);

`ifdef DM_MISALIGN_TRAP_EN
  assign w_misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal | w_misalign;
  assign w_we  = w_accept & we & ~w_err;

  // Halfword/word offsets are forced aligned; with the trap enabled the
  // misaligned cases never reach memory, so the same forcing is harmless.
  always_comb begin
    w_eff_off = 2'b00;
    w_be      = 4'b0000;
    w_lane    = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        w_eff_off = w_off;
        w_be      = 4'b0001 << w_off;
        w_lane    = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_eff_off = {w_off[1], 1'b0};
        w_be      = 4'b0011 << {w_off[1], 1'b0};
        w_lane    = {2{wdata[15:0]}};
      end
      2'b10: begin
        w_eff_off = 2'b00;
        w_be      = 4'b1111;
        w_lane    = wdata;
      end
      default: begin
        w_eff_off = 2'b00;
        w_be      = 4'b0000;
        w_lane    = wdata;
      end
    endcase
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_eff_off, 3'b000};

  always_comb begin
    w_load = 32'h0;
    case (funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_shift[7:0]};
      3'b101:  w_load = {16'h0, w_shift[15:0]};
      default: w_load = 32'h0;
    endcase
  end

  // Storage has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (r_state == StClear) begin
      r_mem[r_clr_idx] <= 32'h0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StClear;
      r_clr_idx   <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rdata     <= (w_accept & ~we & ~w_err) ? w_load : 32'h0;
      r_err       <= w_accept & w_err;
      case (r_state)
        StClear: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
            r_state <= StRun;
            r_ready <= 1'b1;
          end
        end
        StRun: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StClear;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rdata        = r_rdata;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus random traffic against a byte-array model.
module tb_data_mem_ctrl;

  localparam int unsigned D  = 16;
  localparam int unsigned NB = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;
  logic [7:0] mb [NB];

  data_mem_ctrl #(.DEPTH_WORDS(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .addr         (addr),
    .wdata        (wdata),
    .we           (we),
    .funct3       (funct3),
    .rsp_valid    (rsp_valid),
    .rdata        (rdata),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses by size/sign rules.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int size;
    int base;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base = int'(a & 32'(NB - 1));
    e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && f3[2]);
`ifdef DM_MISALIGN_TRAP_EN
    if (!e && (base % size) != 0) e = 1'b1;
`endif
    base = base - (base % size);
    rd = 32'h0;
    if (e) return;
    if (w) begin
      for (int i = 0; i < size; i++) mb[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rd = v;
    end
  endtask

  // Drive one cycle of stimulus at a negedge and check its response one cycle later.
  task automatic step(input logic v, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd_o, output logic err_o);
    logic acc;
    logic e;
    logic [31:0] erd;
    req_valid = v; we = w; funct3 = f3; addr = a; wdata = wd;
    acc = v && req_ready;
    e = 1'b0;
    erd = 32'h0;
    if (acc) model(w, f3, a, wd, e, erd);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rsp_valid a=%h f3=%0d we=%0b", a, f3, w), 32'(rsp_valid), 32'(acc));
    chk($sformatf("rdata a=%h f3=%0d we=%0b", a, f3, w), rdata, erd);
    chk($sformatf("misalign_err a=%h f3=%0d we=%0b", a, f3, w), 32'(misalign_err), 32'(e));
    rd_o = rdata;
    err_o = misalign_err;
    req_valid = 1'b0;
  endtask

  // Release reset at a negedge and measure the not-ready window.
  task automatic sweep(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (!req_ready && cnt < 4 * D) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, 32'(cnt), 32'(D));
    for (int i = 0; i < NB; i++) mb[i] = 8'h0;
  endtask

  logic [31:0] r;
  logic        e;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", 32'(misalign_err), 32'h0);

    sweep("sweep_len");
    step(1'b1, 1'b0, 3'd2, 32'h0000_0000, 32'h0, r, e);
    chk("lw_zero_0", r, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h0000_0038, 32'h0, r, e);
    chk("lw_zero_38", r, 32'h0);

    step(1'b1, 1'b1, 3'd2, 32'h10, 32'h80C0FFEE, r, e);
    step(1'b1, 1'b0, 3'd0, 32'h10, 32'h0, r, e);
    chk("lb_10", r, 32'hFFFFFFEE);
    step(1'b1, 1'b0, 3'd4, 32'h11, 32'h0, r, e);
    chk("lbu_11", r, 32'h000000FF);
    step(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, r, e);
    chk("lh_12", r, 32'hFFFF80C0);
    step(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, r, e);
    chk("lhu_12", r, 32'h000080C0);

    step(1'b1, 1'b1, 3'd2, 32'h20, 32'h11223344, r, e);
    step(1'b1, 1'b1, 3'd0, 32'h21, 32'h000000AA, r, e);
    step(1'b1, 1'b1, 3'd1, 32'h22, 32'h0000BEEF, r, e);
    step(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, r, e);
    chk("merge_lw_20", r, 32'hBEEFAA44);

    step(1'b1, 1'b1, 3'd2, 32'h30, 32'h01234567, r, e);
`ifdef DM_MISALIGN_TRAP_EN
    step(1'b1, 1'b1, 3'd2, 32'h31, 32'hDEADBEEF, r, e);
    chk("sw31_err", 32'(e), 32'h1);
    step(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, r, e);
    chk("lw30_unchanged", r, 32'h01234567);
`else
    step(1'b1, 1'b0, 3'd2, 32'h33, 32'h0, r, e);
    chk("lw33_word30", r, 32'h01234567);
    chk("lw33_no_err", 32'(e), 32'h0);
`endif

    step(1'b1, 1'b1, 3'd2, 32'(NB), 32'h5A5A5A5A, r, e);
    step(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, r, e);
    chk("wrap_lw_0", r, 32'h5A5A5A5A);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, $urandom, r, e);
    end
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, r, e);

    // Reset landing while a load response is on the outputs.
    step(1'b1, 1'b1, 3'd2, 32'h08, 32'hCAFEF00D, r, e);
    req_valid = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h08;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("pre_reset_rdata", rdata, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("async_rdata", rdata, 32'h0);
    chk("async_req_ready", 32'(req_ready), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (D / 2) @(negedge clk);
    chk("mid_sweep_not_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b0;
    sweep("resweep_len");

    step(1'b1, 1'b0, 3'd2, 32'h08, 32'h0, r, e);
    chk("cleared_lw_08", r, 32'h0);
    step(1'b1, 1'b0, 3'd3, 32'h08, 32'h0, r, e);
    chk("illegal_err", 32'(e), 32'h1);
    chk("illegal_rdata", r, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, r, e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
